// File: rtl/uart_tx_protocolo.sv
// uart_tx_protocolo
// Serial UART transmitter. Accepts one parallel word through a valid/ready
// handshake and sends it LSB-first as: start bit, DATA_W data bits, an
// optional parity bit, then one stop bit. Every output is a flop.
//
// Parameters:
//   CLKS_PER_BIT - clock cycles per serial bit (>= 2)
//   DATA_W       - data bits per frame (5..9)
//   PARITY       - 0 none, 1 even, 2 odd (3 behaves as none)
// Ports:
//   clk      - clock, all logic on the rising edge
//   rst_n    - asynchronous active-low reset
//   tx_data  - word to send, sampled only when accepted
//   tx_valid - source has a word
//   tx_ready - transmitter can accept (high only while idle)
//   tx       - serial line, idles high
//   busy     - a frame is on the line
//   done     - one-cycle pulse once the stop bit has finished

module uart_tx_protocolo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_W       = 8,
  parameter int PARITY       = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = $clog2(DATA_W + 1);
  // Only 1 and 2 add a parity bit; the unused encoding 3 falls back to none.
  localparam bit PAR_EN = (PARITY == 1) || (PARITY == 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]  shreg_q, shreg_d;
  logic               par_q, par_d;
  logic               tx_d, busy_d, ready_d, done_d;
  logic               bit_end;

  // The last clock of every bit period; the frame advances one bit here.
  assign bit_end = (cnt_q == CNT_LAST);

  // State, datapath and output registers. The outputs are loaded from the
  // values the output logic predicts for the next state, so they change on
  // the same edge as the state. Reset forces the line high at once and
  // drops any partial frame without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shreg_q  <= '0;
      par_q    <= 1'b0;
      tx       <= 1'b1;
      tx_ready <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shreg_q  <= shreg_d;
      par_q    <= par_d;
      tx       <= tx_d;
      tx_ready <= ready_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

  // Next-state and datapath logic. The word and its parity are captured
  // only at acceptance, so later changes on tx_data/tx_valid are ignored
  // until the transmitter is idle again. The baud counter wraps at the end
  // of every bit period; the shift register moves right between data bits.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    case (state_q)
      S_IDLE: begin
        if (tx_valid && tx_ready) begin
          state_d = S_START;
          cnt_d   = '0;
          idx_d   = '0;
          shreg_d = tx_data;
          par_d   = (PARITY == 2) ? ~(^tx_data) : (^tx_data);
        end
      end
      S_START: begin
        cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
        if (bit_end) begin
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = PAR_EN ? S_PARITY : S_STOP;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            shreg_d = shreg_q >> 1;
          end
        end
      end
      S_PARITY: begin
        cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
        if (bit_end) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // Output logic, decoded from the upcoming state so the registered outputs
  // line up with it. done fires only on the STOP to IDLE step.
  always_comb begin
    tx_d    = 1'b1;
    busy_d  = 1'b1;
    ready_d = 1'b0;
    done_d  = 1'b0;
    case (state_d)
      S_IDLE: begin
        busy_d  = 1'b0;
        ready_d = 1'b1;
        done_d  = (state_q == S_STOP);
      end
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_d[0];
      S_PARITY: tx_d = par_d;
      S_STOP:   tx_d = 1'b1;
      default: begin
        busy_d  = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_protocolo.sv
// tb_uart_tx_protocolo
// Self-checking bench for uart_tx_protocolo. Four transmitters share the
// clock and reset: 8N1, 8E1 and 8O1 at 4 clocks per bit, plus one with the
// unused parity code 3 at 3 clocks per bit. Expected line levels come from
// a frame model that lists the bits of a frame and holds each one for a
// whole bit period.

module tb_uart_tx_protocolo;

  localparam int NI = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] txData  [NI];
  logic       txValid [NI];
  logic       txReady [NI];
  logic       txOut   [NI];
  logic       busyOut [NI];
  logic       doneOut [NI];

  int vecCount = 0;
  int errCount = 0;

  always #5 clk = ~clk;

  uart_tx_protocolo #(.CLKS_PER_BIT(4), .DATA_W(8), .PARITY(0)) u_none (
    .clk(clk), .rst_n(rst_n), .tx_data(txData[0]), .tx_valid(txValid[0]),
    .tx_ready(txReady[0]), .tx(txOut[0]), .busy(busyOut[0]), .done(doneOut[0]));

  uart_tx_protocolo #(.CLKS_PER_BIT(4), .DATA_W(8), .PARITY(1)) u_even (
    .clk(clk), .rst_n(rst_n), .tx_data(txData[1]), .tx_valid(txValid[1]),
    .tx_ready(txReady[1]), .tx(txOut[1]), .busy(busyOut[1]), .done(doneOut[1]));

  uart_tx_protocolo #(.CLKS_PER_BIT(4), .DATA_W(8), .PARITY(2)) u_odd (
    .clk(clk), .rst_n(rst_n), .tx_data(txData[2]), .tx_valid(txValid[2]),
    .tx_ready(txReady[2]), .tx(txOut[2]), .busy(busyOut[2]), .done(doneOut[2]));

  uart_tx_protocolo #(.CLKS_PER_BIT(3), .DATA_W(8), .PARITY(3)) u_illegal (
    .clk(clk), .rst_n(rst_n), .tx_data(txData[3]), .tx_valid(txValid[3]),
    .tx_ready(txReady[3]), .tx(txOut[3]), .busy(busyOut[3]), .done(doneOut[3]));

  // Configuration of each instance as the model sees it.
  function automatic int clksOf(input int inst);
    return (inst == 3) ? 3 : 4;
  endfunction

  function automatic bit hasParity(input int inst);
    return (inst == 1) || (inst == 2);
  endfunction

  // Bit number pos of the frame carrying data: start, 8 data bits LSB first,
  // parity when enabled, stop.
  function automatic logic expectedBit(input int inst, input logic [7:0] data, input int pos);
    int ones;
    ones = $countones(data);
    if (pos == 0) return 1'b0;
    if (pos <= 8) return data[pos-1];
    if (pos == 9 && hasParity(inst)) begin
      if (inst == 1) return logic'(ones % 2);
      return logic'(1 - (ones % 2));
    end
    return 1'b1;
  endfunction

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic got, input logic exp);
    vecCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %b, expected %b", tag, got, exp);
    end
  endtask

  // Checks that every instance sits idle for n cycles: line high, ready,
  // not busy, no done pulse.
  task automatic checkIdle(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        checkOutput($sformatf("idle i%0d tx", i), txOut[i], 1'b1);
        checkOutput($sformatf("idle i%0d ready", i), txReady[i], 1'b1);
        checkOutput($sformatf("idle i%0d busy", i), busyOut[i], 1'b0);
        checkOutput($sformatf("idle i%0d done", i), doneOut[i], 1'b0);
      end
    end
  endtask

  // Sends one frame on an idle instance, starting at a falling edge, and
  // checks every cycle of it up to and including the done cycle. holdValid
  // keeps tx_valid high into the done cycle so the caller can chain the next
  // word back-to-back; scramble churns tx_data/tx_valid during the frame.
  task automatic applyStimulus(input int inst, input logic [7:0] data,
                               input bit holdValid, input bit scramble);
    int c;
    int f;
    string tg;
    c = clksOf(inst);
    f = c * (hasParity(inst) ? 11 : 10);
    txData[inst]  = data;
    txValid[inst] = 1'b1;
    @(posedge clk);
    for (int j = 1; j <= f + 1; j++) begin
      @(negedge clk);
      tg = $sformatf("i%0d d%02h c%0d", inst, data, j);
      if (j <= f) begin
        checkOutput({tg, " tx"}, txOut[inst], expectedBit(inst, data, (j - 1) / c));
        checkOutput({tg, " busy"}, busyOut[inst], 1'b1);
        checkOutput({tg, " ready"}, txReady[inst], 1'b0);
        checkOutput({tg, " done"}, doneOut[inst], 1'b0);
        if (scramble) begin
          txData[inst]  = 8'($urandom);
          txValid[inst] = 1'($urandom);
        end else if (!holdValid) begin
          txValid[inst] = 1'b0;
        end
      end else begin
        checkOutput({tg, " tx"}, txOut[inst], 1'b1);
        checkOutput({tg, " busy"}, busyOut[inst], 1'b0);
        checkOutput({tg, " ready"}, txReady[inst], 1'b1);
        checkOutput({tg, " done"}, doneOut[inst], 1'b1);
        txValid[inst] = holdValid;
      end
    end
  endtask

  // Guards against a stuck run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: reset, directed frames, mid-frame reset, random frames.
  initial begin
    int inst;
    int nextInst;
    logic [7:0] data;
    bit hold;
    bit scr;

    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      txData[i]  = 8'h00;
      txValid[i] = 1'b0;
    end

    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      checkOutput($sformatf("reset i%0d tx", i), txOut[i], 1'b1);
      checkOutput($sformatf("reset i%0d ready", i), txReady[i], 1'b1);
      checkOutput($sformatf("reset i%0d busy", i), busyOut[i], 1'b0);
      checkOutput($sformatf("reset i%0d done", i), doneOut[i], 1'b0);
    end
    rst_n = 1'b1;
    checkIdle(20);

    $display("[TB] 8N1 0xA5");
    applyStimulus(0, 8'hA5, 1'b0, 1'b0);
    checkIdle(2);

    $display("[TB] parity frames 0x07");
    applyStimulus(1, 8'h07, 1'b0, 1'b0);
    checkIdle(1);
    applyStimulus(2, 8'h07, 1'b0, 1'b0);
    checkIdle(1);

    $display("[TB] back-to-back 0x55 then 0x0F");
    applyStimulus(0, 8'h55, 1'b1, 1'b0);
    applyStimulus(0, 8'h0F, 1'b0, 1'b0);
    checkIdle(2);

    $display("[TB] data hold 0x3C");
    applyStimulus(1, 8'h3C, 1'b0, 1'b1);
    checkIdle(1);
    applyStimulus(3, 8'hC3, 1'b0, 1'b0);
    checkIdle(1);

    // Reset lands in data bit 3 (cycles 17..20 after acceptance).
    $display("[TB] reset mid-frame");
    txData[0]  = 8'h96;
    txValid[0] = 1'b1;
    @(posedge clk);
    for (int j = 1; j <= 18; j++) begin
      @(negedge clk);
      txValid[0] = 1'b0;
      checkOutput($sformatf("midrst c%0d tx", j), txOut[0], expectedBit(0, 8'h96, (j - 1) / 4));
    end
    rst_n = 1'b0;
    #1;
    checkOutput("midrst async tx", txOut[0], 1'b1);
    checkOutput("midrst async busy", busyOut[0], 1'b0);
    checkOutput("midrst async ready", txReady[0], 1'b1);
    checkOutput("midrst async done", doneOut[0], 1'b0);
    checkIdle(2);
    rst_n = 1'b1;
    checkIdle(5);
    applyStimulus(0, 8'h81, 1'b0, 1'b0);
    checkIdle(1);

    $display("[TB] random frames");
    nextInst = -1;
    for (int n = 0; n < 16; n++) begin
      inst = (nextInst >= 0) ? nextInst : int'($urandom_range(0, NI - 1));
      data = 8'($urandom);
      hold = ($urandom_range(0, 3) == 0) && (n != 15);
      scr  = 1'($urandom_range(0, 1));
      applyStimulus(inst, data, hold, scr);
      if (hold) begin
        nextInst = inst;
      end else begin
        nextInst = -1;
        checkIdle(int'($urandom_range(0, 2)));
      end
    end
    checkIdle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
